// File: rtl/pilot_draw_con.sv
// pilot_draw_con: pixel colour generator with a button-steered pilot block, moved once per frame
module pilot_draw_con #(
    parameter int H_ACTIVE = 1440,
    parameter int V_ACTIVE = 900,
    parameter int BLK_SIZE = 32,
    parameter int BORDER   = 10,
    parameter int STEP     = 4,
    parameter int START_X  = 704,
    parameter int START_Y  = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_u,
    input  logic        btn_d,
    input  logic        btn_l,
    input  logic        btn_r,
    input  logic        btn_c,
    input  logic        vsync,
    input  logic [10:0] curr_x,
    input  logic [9:0]  curr_y,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic [10:0] blk_x,
    output logic [9:0]  blk_y
);
    localparam logic signed [11:0] H_S   = 12'(H_ACTIVE);
    localparam logic signed [11:0] V_S   = 12'(V_ACTIVE);
    localparam logic signed [11:0] BLK_S = 12'(BLK_SIZE);
    localparam logic signed [11:0] BRD_S = 12'(BORDER);
    localparam logic signed [11:0] STP_S = 12'(STEP);
    localparam logic signed [11:0] X_MAX = 12'(H_ACTIVE - BORDER - BLK_SIZE);
    localparam logic signed [11:0] Y_MAX = 12'(V_ACTIVE - BORDER - BLK_SIZE);

    // synchroniser bit order: {c, u, d, l, r}
    logic [4:0]  sync1_q, sync2_q;
    logic        vsync_q;
    logic [10:0] blk_x_q, blk_x_d;
    logic [9:0]  blk_y_q, blk_y_d;
    logic [11:0] rgb_q, rgb_d;
    logic        frame_tick, s_c, s_u, s_d, s_l, s_r, blank, in_blk, border;
    logic signed [11:0] x_s, y_s, x_up, x_dn, y_up, y_dn, x_nx, y_nx, cx, cy;

    always_comb begin
        {s_c, s_u, s_d, s_l, s_r} = sync2_q;
        frame_tick = vsync_q & ~vsync;
        x_s  = {1'b0, blk_x_q};
        y_s  = {2'b0, blk_y_q};
        x_up = x_s + STP_S;
        x_dn = x_s - STP_S;
        y_up = y_s + STP_S;
        y_dn = y_s - STP_S;
        x_nx = (s_r & ~s_l) ? (x_up > X_MAX ? X_MAX : x_up) :
               (s_l & ~s_r) ? (x_dn < BRD_S ? BRD_S : x_dn) : x_s;
        y_nx = (s_d & ~s_u) ? (y_up > Y_MAX ? Y_MAX : y_up) :
               (s_u & ~s_d) ? (y_dn < BRD_S ? BRD_S : y_dn) : y_s;
        blk_x_d = !frame_tick ? blk_x_q : s_c ? 11'(START_X) : x_nx[10:0];
        blk_y_d = !frame_tick ? blk_y_q : s_c ? 10'(START_Y) : y_nx[9:0];
        cx = {1'b0, curr_x};
        cy = {2'b0, curr_y};
        blank  = (cx >= H_S) || (cy >= V_S);
        in_blk = (cx >= x_s) && (cx < x_s + BLK_S) && (cy >= y_s) && (cy < y_s + BLK_S);
        border = (cx < BRD_S) || (cx >= H_S - BRD_S) || (cy < BRD_S) || (cy >= V_S - BRD_S);
        rgb_d = blank ? 12'h000 : in_blk ? 12'hF00 : border ? 12'hFFF : 12'h004;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            vsync_q <= 1'b1;
            blk_x_q <= 11'(START_X);
            blk_y_q <= 10'(START_Y);
            rgb_q   <= '0;
        end else begin
            sync1_q <= {btn_c, btn_u, btn_d, btn_l, btn_r};
            sync2_q <= sync1_q;
            vsync_q <= vsync;
            blk_x_q <= blk_x_d;
            blk_y_q <= blk_y_d;
            rgb_q   <= rgb_d;
        end
    end

    assign {red, green, blue} = rgb_q;
    assign blk_x = blk_x_q;
    assign blk_y = blk_y_q;
endmodule

// File: tb/tb_pilot_draw_con.sv
// tb_pilot_draw_con: vector table, directed corner sequences and random frames against a reference model
module tb_pilot_draw_con;
    logic clk = 0, rst_n = 0;
    logic btn_u = 0, btn_d = 0, btn_l = 0, btn_r = 0, btn_c = 0, vsync = 1;
    logic [10:0] curr_x = 0;
    logic [9:0]  curr_y = 0;
    logic [3:0]  red, green, blue;
    logic [10:0] blk_x;
    logic [9:0]  blk_y;
    int checks = 0, failures = 0;
    int mx = 704, my = 434;

    typedef struct {int x; int y; int rgb;} vec_t;
    vec_t vt[12];

    pilot_draw_con dut (
        .clk(clk), .rst_n(rst_n), .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l),
        .btn_r(btn_r), .btn_c(btn_c), .vsync(vsync), .curr_x(curr_x), .curr_y(curr_y),
        .red(red), .green(green), .blue(blue), .blk_x(blk_x), .blk_y(blk_y)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic int colour(input int cx, input int cy, input int bx, input int by);
        if (cx >= 1440 || cy >= 900) return 'h000;
        if (cx >= bx && cx < bx + 32 && cy >= by && cy < by + 32) return 'hF00;
        if (cx < 10 || cx >= 1430 || cy < 10 || cy >= 890) return 'hFFF;
        return 'h004;
    endfunction

    task automatic pix(input int cx, input int cy);
        curr_x = 11'(cx);
        curr_y = 10'(cy);
        step();
        check($sformatf("rgb(%0d,%0d)", cx, cy), int'({red, green, blue}), colour(cx, cy, mx, my));
    endtask

    // b = {c, u, d, l, r}
    task automatic frame(input logic [4:0] b);
        {btn_c, btn_u, btn_d, btn_l, btn_r} = b;
        step(); step(); step();
        check("blk_x_before_edge", int'(blk_x), mx);
        vsync = 0;
        step();
        if (b[4]) begin
            mx = 704; my = 434;
        end else begin
            if (b[0] && !b[1]) mx = (mx + 4 > 1398) ? 1398 : mx + 4;
            if (b[1] && !b[0]) mx = (mx - 4 < 10) ? 10 : mx - 4;
            if (b[2] && !b[3]) my = (my + 4 > 858) ? 858 : my + 4;
            if (b[3] && !b[2]) my = (my - 4 < 10) ? 10 : my - 4;
        end
        check("blk_x_at_edge", int'(blk_x), mx);
        check("blk_y_at_edge", int'(blk_y), my);
        vsync = 1;
        step(); step();
        check("blk_x_after_edge", int'(blk_x), mx);
        check("blk_y_after_edge", int'(blk_y), my);
    endtask

    initial begin
        vt[0]  = '{0, 0, 'hFFF};     vt[1]  = '{720, 450, 'hF00};
        vt[2]  = '{1500, 100, 'h000}; vt[3]  = '{704, 434, 'hF00};
        vt[4]  = '{703, 434, 'h004};  vt[5]  = '{735, 465, 'hF00};
        vt[6]  = '{736, 465, 'h004};  vt[7]  = '{9, 450, 'hFFF};
        vt[8]  = '{1430, 5, 'hFFF};   vt[9]  = '{1439, 899, 'hFFF};
        vt[10] = '{1440, 0, 'h000};   vt[11] = '{100, 100, 'h004};
        #12;
        check("reset_rgb", int'({red, green, blue}), 0);
        check("reset_blk_x", int'(blk_x), 704);
        check("reset_blk_y", int'(blk_y), 434);
        rst_n = 1;
        step();
        for (int i = 0; i < 12; i++) begin
            curr_x = 11'(vt[i].x);
            curr_y = 10'(vt[i].y);
            step();
            check($sformatf("vec%0d", i), int'({red, green, blue}), vt[i].rgb);
        end
        for (int i = 0; i < 3; i++) begin
            frame(5'b00001);
            check("right_step", int'(blk_x), 708 + 4 * i);
        end
        for (int i = 0; i < 200; i++) frame(5'b00010);
        check("left_saturate", int'(blk_x), 10);
        pix(9, 450);
        pix(10, 450);
        check("left_edge_red", int'({red, green, blue}), 'hF00);
        for (int i = 0; i < 120; i++) frame(5'b00100);
        check("down_clamp", int'(blk_y), 858);
        for (int i = 0; i < 5; i++) frame(5'b01100);
        check("ud_hold", int'(blk_y), 858);
        for (int i = 0; i < 400; i++) frame(5'b00001);
        check("right_clamp", int'(blk_x), 1398);
        frame(5'b10001);
        check("recentre_x", int'(blk_x), 704);
        check("recentre_y", int'(blk_y), 434);
        for (int i = 0; i < 49; i++) frame(5'b00001);
        check("at_900", int'(blk_x), 900);
        frame(5'b00000);
        pix(910, 440);
        #2 rst_n = 0;
        #1;
        check("async_rgb", int'({red, green, blue}), 0);
        check("async_blk_x", int'(blk_x), 704);
        mx = 704; my = 434;
        step();
        rst_n = 1;
        pix(720, 450);
        for (int i = 0; i < 60; i++) begin
            frame(5'($urandom_range(0, 31) & ((i % 7 == 0) ? 31 : 15)));
            for (int k = 0; k < 4; k++) begin
                if (k < 2) pix(mx + $urandom_range(0, 40) - 4, my + $urandom_range(0, 40) - 4);
                else pix($urandom_range(0, 2047), $urandom_range(0, 1023));
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
